mcu_top: RTL and testbench

MCU_TOP -- requirements
Module: mcu_top

---
 rtl/mcu_top.sv | 176 +++++++++++++++++
 tb/tb_mcu_top.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mcu_top.sv
// JTAG-accessible 16 x 32-bit register file. TCK, TMS, TDI and TRST are oversampled by CLK,
// so the TAP and the memory run entirely in the CLK domain.
module mcu_top #(
  parameter logic [31:0] IDCODE_VAL = 32'h4BA00477
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic TCK,
  input  logic TMS,
  input  logic TDI,
  input  logic TRST,
  output logic TDO
);

  localparam logic [3:0] INS_IDCODE = 4'h1;
  localparam logic [3:0] INS_ADDR   = 4'h8;
  localparam logic [3:0] INS_DATA   = 4'h9;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_t;

  // Bit order of the synchronized bus: {TRST, TDI, TMS, TCK}
  logic [3:0] pin_raw;
  logic [3:0] pin_sync;
  logic       tck_s;
  logic       tms_s;
  logic       tdi_s;
  logic       trst_s;
  logic       tck_prev_reg;
  logic       tck_rise;
  logic       tck_fall;

  tap_state_t  state_reg;
  tap_state_t  state_next;

  logic [3:0]  ir_reg;
  logic [3:0]  ir_shift_reg;
  logic [31:0] dr_shift_reg;
  logic [3:0]  addr_reg;
  logic        tdo_reg;

  logic [31:0] mem [16];
  logic [31:0] mem_rdata_reg;
  logic        mem_we;

  assign pin_raw = {TRST, TDI, TMS, TCK};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      always_ff @(posedge CLK) begin
        if (RSTN) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else begin
          s1_reg <= pin_raw[gi];
          s2_reg <= s1_reg;
        end
      end
      assign pin_sync[gi] = s2_reg;
    end
  endgenerate

  assign tck_s  = pin_sync[0];
  assign tms_s  = pin_sync[1];
  assign tdi_s  = pin_sync[2];
  assign trst_s = pin_sync[3];

  always_ff @(posedge CLK) begin
    if (RSTN) tck_prev_reg <= 1'b0;
    else      tck_prev_reg <= tck_s;
  end

  assign tck_rise = tck_s & ~tck_prev_reg;
  assign tck_fall = ~tck_s & tck_prev_reg;

  // TAP state register: RSTN first, then the synchronized active-low TRST
  always_ff @(posedge CLK) begin
    if (RSTN || !trst_s) state_reg <= TLR;
    else if (tck_rise)   state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      TLR:     state_next = tms_s ? TLR    : RTI;
      RTI:     state_next = tms_s ? SEL_DR : RTI;
      SEL_DR:  state_next = tms_s ? SEL_IR : CAP_DR;
      CAP_DR:  state_next = tms_s ? EX1_DR : SH_DR;
      SH_DR:   state_next = tms_s ? EX1_DR : SH_DR;
      EX1_DR:  state_next = tms_s ? UPD_DR : PAU_DR;
      PAU_DR:  state_next = tms_s ? EX2_DR : PAU_DR;
      EX2_DR:  state_next = tms_s ? UPD_DR : SH_DR;
      UPD_DR:  state_next = tms_s ? SEL_DR : RTI;
      SEL_IR:  state_next = tms_s ? TLR    : CAP_IR;
      CAP_IR:  state_next = tms_s ? EX1_IR : SH_IR;
      SH_IR:   state_next = tms_s ? EX1_IR : SH_IR;
      EX1_IR:  state_next = tms_s ? UPD_IR : PAU_IR;
      PAU_IR:  state_next = tms_s ? EX2_IR : PAU_IR;
      EX2_IR:  state_next = tms_s ? UPD_IR : SH_IR;
      UPD_IR:  state_next = tms_s ? SEL_DR : RTI;
      default: state_next = TLR;
    endcase
  end

  // Register actions are keyed on the state being left at a TCK rise
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      ir_reg       <= INS_IDCODE;
      ir_shift_reg <= 4'd0;
      dr_shift_reg <= 32'd0;
      addr_reg     <= 4'd0;
      tdo_reg      <= 1'b0;
    end else if (!trst_s) begin
      ir_reg  <= INS_IDCODE;
      tdo_reg <= 1'b0;
    end else begin
      if (state_reg == TLR) ir_reg <= INS_IDCODE;

      if (tck_rise) begin
        case (state_reg)
          CAP_IR: ir_shift_reg <= 4'b0001;
          SH_IR:  ir_shift_reg <= {tdi_s, ir_shift_reg[3:1]};
          UPD_IR: ir_reg <= ir_shift_reg;
          CAP_DR: begin
            case (ir_reg)
              INS_IDCODE: dr_shift_reg <= IDCODE_VAL;
              INS_ADDR:   dr_shift_reg <= {28'd0, addr_reg};
              INS_DATA:   dr_shift_reg <= mem_rdata_reg;
              default:    dr_shift_reg <= 32'd0;
            endcase
          end
          SH_DR: begin
            case (ir_reg)
              INS_IDCODE, INS_DATA: dr_shift_reg <= {tdi_s, dr_shift_reg[31:1]};
              INS_ADDR:             dr_shift_reg[3:0] <= {tdi_s, dr_shift_reg[3:1]};
              default:              dr_shift_reg[0] <= tdi_s;
            endcase
          end
          UPD_DR: begin
            if (ir_reg == INS_ADDR)      addr_reg <= dr_shift_reg[3:0];
            else if (ir_reg == INS_DATA) addr_reg <= addr_reg + 4'd1;
          end
          default: ;
        endcase
      end

      if (tck_fall) begin
        if (state_reg == SH_IR)      tdo_reg <= ir_shift_reg[0];
        else if (state_reg == SH_DR) tdo_reg <= dr_shift_reg[0];
        else                         tdo_reg <= 1'b0;
      end
    end
  end

  assign mem_we = tck_rise && trst_s && (state_reg == UPD_DR) && (ir_reg == INS_DATA);

  // Read port is registered; many CLK cycles separate an address change from the next Capture-DR
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      mem_rdata_reg <= 32'd0;
    end else begin
      if (mem_we) mem[addr_reg] <= dr_shift_reg;
      mem_rdata_reg <= mem[addr_reg];
    end
  end

  assign TDO = tdo_reg;

endmodule

// File: tb/tb_mcu_top.sv
// Directed bench for mcu_top: drives JTAG through slow TCK cycles and checks TDO streams.
module tb_mcu_top;

  logic CLK;
  logic RSTN;
  logic TCK;
  logic TMS;
  logic TDI;
  logic TRST;
  logic TDO;

  int tests_run;
  int tests_failed;

  localparam logic [31:0] IDCODE = 32'h4BA00477;

  mcu_top #(.IDCODE_VAL(IDCODE)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .TCK  (TCK),
    .TMS  (TMS),
    .TDI  (TDI),
    .TRST (TRST),
    .TDO  (TDO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  ir;
    int          nbits;
    logic [31:0] din;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %08h", name, act);
    end
  endtask

  // One TCK period: fall (with new TMS/TDI), low phase, sample TDO, rise, high phase
  task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo_bit);
    TCK = 1'b0;
    TMS = tms;
    TDI = tdi;
    repeat (6) @(posedge CLK);
    #1;
    tdo_bit = TDO;
    TCK = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
  endtask

  // From Run-Test/Idle, through Shift-IR, back to Run-Test/Idle
  task automatic load_ir(input logic [3:0] ir, output logic [3:0] cap);
    logic b;
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < 4; i++) begin
      tck_cycle(i == 3, ir[i], b);
      cap[i] = b;
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
  endtask

  // From Run-Test/Idle, through Shift-DR (n bits), back to Run-Test/Idle
  task automatic shift_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
    logic b;
    dout = 32'd0;
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], b);
      dout[i] = b;
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
  endtask

  initial begin
    logic [3:0]  cap;
    logic [31:0] dout;
    logic        b;

    tests_run    = 0;
    tests_failed = 0;

    vecs[0]  = '{4'h1, 32, 32'h0,        IDCODE,       "idcode_again"};
    vecs[1]  = '{4'hF, 4,  32'hD,        32'hA,        "bypass_1011"};
    vecs[2]  = '{4'h5, 3,  32'h3,        32'h6,        "bypass_code5"};
    vecs[3]  = '{4'h8, 4,  32'h3,        32'h0,        "addr_set3"};
    vecs[4]  = '{4'h9, 32, 32'hDEADBEEF, 32'h0,        "data_wr3"};
    vecs[5]  = '{4'h8, 4,  32'h3,        32'h4,        "addr_after_wr"};
    vecs[6]  = '{4'h9, 32, 32'hDEADBEEF, 32'hDEADBEEF, "data_rd3"};
    vecs[7]  = '{4'h8, 4,  32'hF,        32'h4,        "addr_set15"};
    vecs[8]  = '{4'h9, 32, 32'h12345678, 32'h0,        "data_wr15"};
    vecs[9]  = '{4'h8, 4,  32'h0,        32'h0,        "addr_wrapped"};
    vecs[10] = '{4'h9, 32, 32'hA5A5A5A5, 32'h0,        "mem0_zero"};
    vecs[11] = '{4'h8, 4,  32'hF,        32'h1,        "addr_after_mem0"};
    vecs[12] = '{4'h9, 32, 32'h0,        32'h12345678, "data_rd15"};
    vecs[13] = '{4'h8, 4,  32'h0,        32'h0,        "addr_wrap2"};
    vecs[14] = '{4'h9, 32, 32'h0,        32'hA5A5A5A5, "data_rd0"};

    // Reset with pins idle
    TCK = 1'b0; TMS = 1'b0; TDI = 1'b0; TRST = 1'b1; RSTN = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    RSTN = 1'b0;
    #1;
    check("reset_tdo", {31'd0, TDO}, 32'd0);
    repeat (10) @(posedge CLK);
    #1;
    check("idle_tdo", {31'd0, TDO}, 32'd0);

    // IDCODE selected straight out of reset
    tck_cycle(1'b0, 1'b0, b);
    shift_dr(32'd0, 32, dout);
    check("reset_idcode", dout, IDCODE);

    load_ir(4'hF, cap);
    check("ir_capture", {28'd0, cap}, 32'h1);

    for (int v = 0; v < 15; v++) begin
      load_ir(vecs[v].ir, cap);
      shift_dr(vecs[v].din, vecs[v].nbits, dout);
      check(vecs[v].name, dout, vecs[v].exp);
    end

    // TRST asserted part-way through a DATA shift
    load_ir(4'h8, cap);
    shift_dr(32'h3, 4, dout);
    check("addr_before_trst", dout, 32'h1);
    load_ir(4'h9, cap);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < 7; i++) tck_cycle(1'b0, 1'b0, b);
    check("tdo_midshift", {31'd0, TDO}, 32'd1);
    TRST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    TRST = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    check("tdo_after_trst", {31'd0, TDO}, 32'd0);
    tck_cycle(1'b0, 1'b0, b);
    shift_dr(32'd0, 32, dout);
    check("idcode_after_trst", dout, IDCODE);
    load_ir(4'h8, cap);
    shift_dr(32'h3, 4, dout);
    check("addr_kept_trst", dout, 32'h3);
    load_ir(4'h9, cap);
    shift_dr(32'hDEADBEEF, 32, dout);
    check("mem_kept_trst", dout, 32'hDEADBEEF);

    // Five TMS=1 rises from Shift-DR must land in Test-Logic-Reset
    load_ir(4'h8, cap);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b1, b);
    tck_cycle(1'b0, 1'b0, b);
    shift_dr(32'd0, 32, dout);
    check("five_tms_tlr", dout, IDCODE);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
